// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sseg_pkg
// Description : Shared constants and helpers for the seven-segment scanner.
// Revision    : 1.0 - initial release
// ============================================================================

package sseg_pkg;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam int         MAX_DIGITS = 8;
  localparam int         CODE_W     = 5;

  // Active-low gfedcba patterns for hex values 0..F.
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  localparam logic [6:0] SEG_TABLE [16] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
  };

  // Digit k of a packed code word sized for the largest supported display.
  function automatic logic [CODE_W-1:0] digit_slice(
    input logic [CODE_W*MAX_DIGITS-1:0] word,
    input logic [2:0]                   k
  );
    return word[CODE_W*int'(k) +: CODE_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sseg_hex_decode.sv
`default_nettype none
// ============================================================================
// Module      : sseg_hex_decode
// Description : Hex value plus decimal point to active-low segment pattern.
// Revision    : 1.0 - initial release
// ============================================================================

module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [3:0] value,
  input  logic       dp,
  output logic [7:0] segs
);

  always_comb begin
    segs = {~dp, SEG_TABLE[value]};
  end

endmodule

`default_nettype wire

// File: rtl/sseg_scan.sv
`default_nettype none
// ============================================================================
// Module      : sseg_scan
// Description : Multiplexed seven-segment driver with double-buffered load,
//               per-digit blank/blink, PWM brightness and frame-start pulse.
// Revision    : 1.0 - initial release
// ============================================================================

module sseg_scan
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 6,
  parameter int SCAN_DIV    = 50000,
  parameter int BRIGHT_BITS = 4,
  parameter int BLINK_DIV   = 60
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CODE_W*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]        blank_mask,
  input  logic [NUM_DIGITS-1:0]        blink_mask,
  input  logic                         load,
  input  logic [BRIGHT_BITS-1:0]       brightness,
  output logic [7:0]                   digit_segs,
  output logic [NUM_DIGITS-1:0]        position,
  output logic                         frame_start
);

  localparam int WORD_W = CODE_W * NUM_DIGITS;
  localparam int PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SLOT_W = $clog2(NUM_DIGITS);
  localparam int FRM_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BLINK_DIV - 1);

  // Scan timing state
  logic [PRE_W-1:0]  pre_q,   pre_d;
  logic [SLOT_W-1:0] slot_q,  slot_d;
  logic [FRM_W-1:0]  frm_q,   frm_d;
  logic              blink_q, blink_d;

  // Double-buffered display content
  logic              pend_q,          pend_d;
  logic [WORD_W-1:0] stage_digits_q,  stage_digits_d;
  logic [NUM_DIGITS-1:0] stage_blank_q, stage_blank_d;
  logic [NUM_DIGITS-1:0] stage_blink_q, stage_blink_d;
  logic [WORD_W-1:0] shadow_digits_q, shadow_digits_d;
  logic [NUM_DIGITS-1:0] shadow_blank_q, shadow_blank_d;
  logic [NUM_DIGITS-1:0] shadow_blink_q, shadow_blink_d;

  // Registered outputs
  logic [7:0]            segs_q,  segs_d;
  logic [NUM_DIGITS-1:0] pos_q,   pos_d;
  logic                  fs_q,    fs_d;

  logic                          pre_wrap;
  logic                          frame_end;
  logic [CODE_W*MAX_DIGITS-1:0]  shadow_word;
  logic [CODE_W-1:0]             cur_code;
  logic [7:0]                    dec_segs;
  logic                          lit;

  always_comb begin
    pre_wrap  = (pre_q == PRE_LAST);
    frame_end = pre_wrap && (slot_q == SLOT_LAST);
  end

  always_comb begin
    pre_d   = pre_wrap ? '0 : pre_q + 1'b1;
    slot_d  = slot_q;
    frm_d   = frm_q;
    blink_d = blink_q;
    if (pre_wrap) begin
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
    end
    if (frame_end) begin
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        blink_d = ~blink_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end
  end

  // A load on the boundary cycle bypasses staging so it shows in the new frame.
  always_comb begin
    stage_digits_d  = load ? digits_in  : stage_digits_q;
    stage_blank_d   = load ? blank_mask : stage_blank_q;
    stage_blink_d   = load ? blink_mask : stage_blink_q;
    pend_d          = pend_q | load;
    shadow_digits_d = shadow_digits_q;
    shadow_blank_d  = shadow_blank_q;
    shadow_blink_d  = shadow_blink_q;
    if (frame_end) begin
      pend_d = 1'b0;
      if (load) begin
        shadow_digits_d = digits_in;
        shadow_blank_d  = blank_mask;
        shadow_blink_d  = blink_mask;
      end else if (pend_q) begin
        shadow_digits_d = stage_digits_q;
        shadow_blank_d  = stage_blank_q;
        shadow_blink_d  = stage_blink_q;
      end
    end
  end

  always_comb begin
    shadow_word             = '0;
    shadow_word[WORD_W-1:0] = shadow_digits_q;
    cur_code                = digit_slice(shadow_word, 3'(slot_q));
  end

  sseg_hex_decode u_decode (
    .value (cur_code[3:0]),
    .dp    (cur_code[4]),
    .segs  (dec_segs)
  );

  always_comb begin
    lit = !shadow_blank_q[slot_q]
       && !(shadow_blink_q[slot_q] && !blink_q)
       && (pre_q[BRIGHT_BITS-1:0] <= brightness);
    segs_d = lit ? dec_segs : SEG_BLANK;
    pos_d  = '1;
    if (lit) begin
      pos_d[NUM_DIGITS-1-int'(slot_q)] = 1'b0;
    end
    fs_d = (slot_q == '0) && (pre_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q           <= '0;
      slot_q          <= '0;
      frm_q           <= '0;
      blink_q         <= 1'b1;
      pend_q          <= 1'b0;
      stage_digits_q  <= '0;
      stage_blank_q   <= '0;
      stage_blink_q   <= '0;
      shadow_digits_q <= '0;
      shadow_blank_q  <= '0;
      shadow_blink_q  <= '0;
      segs_q          <= SEG_BLANK;
      pos_q           <= '1;
      fs_q            <= 1'b0;
    end else begin
      pre_q           <= pre_d;
      slot_q          <= slot_d;
      frm_q           <= frm_d;
      blink_q         <= blink_d;
      pend_q          <= pend_d;
      stage_digits_q  <= stage_digits_d;
      stage_blank_q   <= stage_blank_d;
      stage_blink_q   <= stage_blink_d;
      shadow_digits_q <= shadow_digits_d;
      shadow_blank_q  <= shadow_blank_d;
      shadow_blink_q  <= shadow_blink_d;
      segs_q          <= segs_d;
      pos_q           <= pos_d;
      fs_q            <= fs_d;
    end
  end

  assign digit_segs  = segs_q;
  assign position    = pos_q;
  assign frame_start = fs_q;

endmodule

`default_nettype wire
